// File: rtl/el2_ifu_ib_queue.sv
// el2_ifu_ib_queue: DEPTH-entry circular queue of aligned i0 packets feeding decode.
// Optional macro IB_BYPASS_EN forwards an incoming packet to decode combinationally when the queue is empty.
module el2_ifu_ib_queue #(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       exu_flush_final,
   input  logic                       ifu_i0_valid,
   input  logic [31:0]                ifu_i0_instr,
   input  logic [30:0]                ifu_i0_pc,
   input  logic                       ifu_i0_pc4,
   input  logic                       ifu_i0_icaf,
   input  logic [1:0]                 ifu_i0_icaf_type,
   input  logic                       ifu_i0_icaf_second,
   input  logic                       ifu_i0_dbecc,
   output logic                       ifu_ib_ready,
   output logic                       ib_i0_valid,
   output logic [31:0]                ib_i0_instr,
   output logic [30:0]                ib_i0_pc,
   output logic                       ib_i0_pc4,
   output logic                       ib_i0_icaf,
   output logic [1:0]                 ib_i0_icaf_type,
   output logic                       ib_i0_icaf_second,
   output logic                       ib_i0_dbecc,
   input  logic                       dec_ib_take,
   output logic [$clog2(DEPTH):0]     ib_count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   typedef struct packed {
      logic [31:0] instr;
      logic [30:0] pc;
      logic        pc4;
      logic        icaf;
      logic [1:0]  icaf_type;
      logic        icaf_second;
      logic        dbecc;
   } ib_pkt_t;

   ib_pkt_t       mem [DEPTH];
   ib_pkt_t       in_pkt;
   ib_pkt_t       head;
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [CW-1:0] count;
   logic          byp;
   logic          push;
   logic          pop;

   assign in_pkt = '{instr: ifu_i0_instr, pc: ifu_i0_pc, pc4: ifu_i0_pc4, icaf: ifu_i0_icaf,
                     icaf_type: ifu_i0_icaf_type, icaf_second: ifu_i0_icaf_second,
                     dbecc: ifu_i0_dbecc};

   assign ifu_ib_ready = (count != FULL);
   assign ib_count     = count;

`ifdef IB_BYPASS_EN
   // rst gate keeps the outputs at their reset values while reset is held
   assign byp         = !rst & (count == '0) & ifu_i0_valid & !exu_flush_final;
   assign ib_i0_valid = (count != '0) | byp;
   assign head        = byp ? in_pkt : mem[rd_ptr];
`else
   assign byp         = 1'b0;
   assign ib_i0_valid = (count != '0);
   assign head        = mem[rd_ptr];
`endif

   // A bypassed packet taken in the same cycle never enters storage
   assign push = ifu_i0_valid & ifu_ib_ready & !exu_flush_final & !(byp & dec_ib_take);
   assign pop  = dec_ib_take & (count != '0) & !exu_flush_final;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (push) begin
         mem[wr_ptr] <= in_pkt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (exu_flush_final) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   assign ib_i0_instr       = head.instr;
   assign ib_i0_pc          = head.pc;
   assign ib_i0_pc4         = head.pc4;
   assign ib_i0_icaf        = head.icaf;
   assign ib_i0_icaf_type   = head.icaf_type;
   assign ib_i0_icaf_second = head.icaf_second;
   assign ib_i0_dbecc       = head.dbecc;

endmodule

// File: tb/tb_el2_ifu_ib_queue.sv
// Directed bench for el2_ifu_ib_queue: expected packets queue up at issue and a monitor checks each take.
module tb_el2_ifu_ib_queue;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic [31:0] instr;
      logic [30:0] pc;
      logic        pc4;
      logic        icaf;
      logic [1:0]  icaf_type;
      logic        icaf_second;
      logic        dbecc;
   } pkt_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          exu_flush_final = 1'b0;
   logic          ifu_i0_valid = 1'b0;
   logic [31:0]   ifu_i0_instr = '0;
   logic [30:0]   ifu_i0_pc = '0;
   logic          ifu_i0_pc4 = 1'b0;
   logic          ifu_i0_icaf = 1'b0;
   logic [1:0]    ifu_i0_icaf_type = '0;
   logic          ifu_i0_icaf_second = 1'b0;
   logic          ifu_i0_dbecc = 1'b0;
   logic          dec_ib_take = 1'b0;
   logic          ifu_ib_ready;
   logic          ib_i0_valid;
   logic [31:0]   ib_i0_instr;
   logic [30:0]   ib_i0_pc;
   logic          ib_i0_pc4;
   logic          ib_i0_icaf;
   logic [1:0]    ib_i0_icaf_type;
   logic          ib_i0_icaf_second;
   logic          ib_i0_dbecc;
   logic [CW-1:0] ib_count;

   int   passed = 0;
   int   total  = 0;
   pkt_t sb[$];

   el2_ifu_ib_queue #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .exu_flush_final(exu_flush_final),
      .ifu_i0_valid(ifu_i0_valid), .ifu_i0_instr(ifu_i0_instr), .ifu_i0_pc(ifu_i0_pc),
      .ifu_i0_pc4(ifu_i0_pc4), .ifu_i0_icaf(ifu_i0_icaf), .ifu_i0_icaf_type(ifu_i0_icaf_type),
      .ifu_i0_icaf_second(ifu_i0_icaf_second), .ifu_i0_dbecc(ifu_i0_dbecc),
      .ifu_ib_ready(ifu_ib_ready), .ib_i0_valid(ib_i0_valid), .ib_i0_instr(ib_i0_instr),
      .ib_i0_pc(ib_i0_pc), .ib_i0_pc4(ib_i0_pc4), .ib_i0_icaf(ib_i0_icaf),
      .ib_i0_icaf_type(ib_i0_icaf_type), .ib_i0_icaf_second(ib_i0_icaf_second),
      .ib_i0_dbecc(ib_i0_dbecc), .dec_ib_take(dec_ib_take), .ib_count(ib_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   // Ordinary packet keyed on a full byte PC
   function automatic pkt_t mk(input logic [31:0] pc);
      pkt_t p;
      p             = '0;
      p.instr       = 32'hA000_0000 | pc;
      p.pc          = pc[31:1];
      p.pc4         = 1'b1;
      return p;
   endfunction

   task automatic drive(input pkt_t p, input bit v, input bit take, input bit fl, input bit acc);
      ifu_i0_valid    = v;
      {ifu_i0_instr, ifu_i0_pc, ifu_i0_pc4, ifu_i0_icaf, ifu_i0_icaf_type,
       ifu_i0_icaf_second, ifu_i0_dbecc} = p;
      dec_ib_take     = take;
      exu_flush_final = fl;
      if (v && acc) sb.push_back(p);
      #1;
   endtask

   task automatic idle();
      drive('0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every accepted take must deliver the oldest expected packet unchanged
   initial begin
      pkt_t got;
      pkt_t exp;
      forever begin
         @(negedge clk);
         if (!rst && ib_i0_valid && dec_ib_take && !exu_flush_final) begin
            got = {ib_i0_instr, ib_i0_pc, ib_i0_pc4, ib_i0_icaf, ib_i0_icaf_type,
                   ib_i0_icaf_second, ib_i0_dbecc};
            total++;
            if (sb.size() == 0) begin
               $display("FAIL take_unexpected: got %h expected no packet", got);
            end else begin
               exp = sb.pop_front();
               if (got === exp) passed++;
               else $display("FAIL take_pkt: got %h expected %h", got, exp);
            end
         end
      end
   end

   initial begin
      pkt_t f;
      // Reset values
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", 64'(ifu_ib_ready), 64'd1);
      chk("rst_valid", 64'(ib_i0_valid), 64'd0);
      chk("rst_count", 64'(ib_count), 64'd0);
      chk("rst_instr", 64'(ib_i0_instr), 64'd0);
      chk("rst_pc", 64'(ib_i0_pc), 64'd0);
      rst = 1'b0;

      // Fill to DEPTH, then a refused fifth push
      drive(mk(32'h100), 1, 0, 0, 1); tick();
      chk("lat1_valid", 64'(ib_i0_valid), 64'd1);
      drive(mk(32'h102), 1, 0, 0, 1); tick();
      drive(mk(32'h106), 1, 0, 0, 1); tick();
      drive(mk(32'h10A), 1, 0, 0, 1); tick();
      chk("full_count", 64'(ib_count), 64'd4);
      chk("full_ready", 64'(ifu_ib_ready), 64'd0);
      drive(mk(32'h10E), 1, 0, 0, 0); tick();
      chk("refused_count", 64'(ib_count), 64'd4);
      chk("refused_head", 64'(ib_i0_pc), 64'(32'h100 >> 1));

      // Drain on four consecutive takes
      drive('0, 0, 1, 0, 0); tick();
      chk("drain1_ready", 64'(ifu_ib_ready), 64'd1);
      chk("drain1_count", 64'(ib_count), 64'd3);
      drive('0, 0, 1, 0, 0); tick();
      drive('0, 0, 1, 0, 0); tick();
      drive('0, 0, 1, 0, 0); tick();
      idle();
      chk("drain_count", 64'(ib_count), 64'd0);
      chk("drain_valid", 64'(ib_i0_valid), 64'd0);

      // Take while empty is ignored
      drive('0, 0, 1, 0, 0); tick();
      idle();
      chk("underflow_count", 64'(ib_count), 64'd0);

      // Steady state at count 2, pointers wrap
      drive(mk(32'h300), 1, 0, 0, 1); tick();
      drive(mk(32'h304), 1, 0, 0, 1); tick();
      for (int i = 0; i < 10; i++) begin
         drive(mk(32'h308 + 32'(4 * i)), 1, 1, 0, 1); tick();
         chk("stream_count", 64'(ib_count), 64'd2);
      end
      drive('0, 0, 1, 0, 0); tick();
      drive('0, 0, 1, 0, 0); tick();
      idle();
      chk("stream_empty", 64'(ib_count), 64'd0);

      // Flush with a simultaneous push and take
      drive(mk(32'h400), 1, 0, 0, 1); tick();
      drive(mk(32'h402), 1, 0, 0, 1); tick();
      drive(mk(32'h404), 1, 0, 0, 1); tick();
      chk("preflush_count", 64'(ib_count), 64'd3);
      drive(mk(32'h406), 1, 1, 1, 0); tick();
      sb.delete();
      idle();
      chk("flush_count", 64'(ib_count), 64'd0);
      chk("flush_valid", 64'(ib_i0_valid), 64'd0);
      chk("flush_ready", 64'(ifu_ib_ready), 64'd1);
      tick();
      chk("flush_stays_empty", 64'(ib_i0_valid), 64'd0);

      // Fault bits pass through untouched
      f             = '0;
      f.instr       = 32'h0000_0013;
      f.pc          = 31'(32'h208 >> 1);
      f.pc4         = 1'b1;
      f.icaf        = 1'b1;
      f.icaf_type   = 2'd2;
      f.icaf_second = 1'b1;
      f.dbecc       = 1'b1;
      drive(f, 1, 0, 0, 1); tick();
      idle();
      chk("fault_instr", 64'(ib_i0_instr), 64'h13);
      chk("fault_type", 64'(ib_i0_icaf_type), 64'd2);
      chk("fault_dbecc", 64'(ib_i0_dbecc), 64'd1);
      drive('0, 0, 1, 0, 0); tick();
      idle();

      // Push into an empty queue with a same-cycle take
      drive(mk(32'h200), 1, 1, 0, 1);
`ifdef IB_BYPASS_EN
      chk("byp_valid", 64'(ib_i0_valid), 64'd1);
      chk("byp_pc", 64'(ib_i0_pc), 64'(32'h200 >> 1));
      tick();
      idle();
      chk("byp_count", 64'(ib_count), 64'd0);
      chk("byp_after_valid", 64'(ib_i0_valid), 64'd0);
`else
      chk("nobyp_valid", 64'(ib_i0_valid), 64'd0);
      tick();
      idle();
      chk("nobyp_next_valid", 64'(ib_i0_valid), 64'd1);
      chk("nobyp_next_pc", 64'(ib_i0_pc), 64'(32'h200 >> 1));
      chk("nobyp_count", 64'(ib_count), 64'd1);
      drive('0, 0, 1, 0, 0); tick();
      idle();
`endif

      // Asynchronous reset in the middle of a cycle
      drive(mk(32'h500), 1, 0, 0, 1); tick();
      drive(mk(32'h504), 1, 0, 0, 1); tick();
      idle();
      rst = 1'b1;
      #1;
      chk("arst_count", 64'(ib_count), 64'd0);
      chk("arst_valid", 64'(ib_i0_valid), 64'd0);
      chk("arst_pc", 64'(ib_i0_pc), 64'd0);
      sb.delete();
      tick();
      rst = 1'b0;
      tick();
      chk("post_rst_ready", 64'(ifu_ib_ready), 64'd1);

      chk("sb_empty", 64'(sb.size()), 64'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/el2_ifu_ib_queue.md
# el2_ifu_ib_queue

Instruction queue between the IFU aligner and the decode instruction-buffer control. Holds up to DEPTH aligned i0 instruction packets (instruction, PC, size, fault bits) and presents the oldest to decode with valid/take handshaking. It applies back-pressure to the aligner when full and discards all contents on a pipeline flush. It decouples aligner output bursts from decode stalls.

## Interface

Parameters:
- DEPTH, default 4: number of entries. Must be a power of two, at least 2.

Ports:
- clk  in  1  core clock.
- rst  in  1  reset; asynchronous, active-high.
- exu_flush_final  in  1  pipeline flush; empties the queue.
- ifu_i0_valid  in  1  aligner presents a packet.
- ifu_i0_instr  in  32  instruction.
- ifu_i0_pc  in  31  PC[31:1].
- ifu_i0_pc4  in  1  4-byte instruction; 0 means 2-byte.
- ifu_i0_icaf  in  1  instruction access fault.
- ifu_i0_icaf_type  in  2  access fault type.
- ifu_i0_icaf_second  in  1  fault on the second half of a 4-byte instruction.
- ifu_i0_dbecc  in  1  double-bit ECC error.
- ifu_ib_ready  out  1  queue can accept a packet this cycle.
- ib_i0_valid  out  1  head packet valid toward decode.
- ib_i0_instr, ib_i0_pc, ib_i0_pc4, ib_i0_icaf, ib_i0_icaf_type, ib_i0_icaf_second, ib_i0_dbecc  out  same widths as the inputs  head packet fields.
- dec_ib_take  in  1  decode consumes the head this cycle. Only meaningful when ib_i0_valid=1.
- ib_count  out  $clog2(DEPTH)+1  current occupancy.

## Operation

- Storage is a circular buffer with rd_ptr and wr_ptr, each $clog2(DEPTH) bits, plus count, $clog2(DEPTH)+1 bits.
- Pointers increment modulo DEPTH; wrap from DEPTH-1 to 0 is natural overflow.
- ifu_ib_ready = (count != DEPTH). It is not relaxed by a same-cycle take.
- Push occurs when ifu_i0_valid & ifu_ib_ready & !exu_flush_final. The packet is written at wr_ptr, and wr_ptr increments.
- Pop occurs when dec_ib_take & ib_i0_valid & !exu_flush_final. rd_ptr increments.
- Count update: push only gives +1; pop only gives -1; push and pop together leave it unchanged.
- dec_ib_take while ib_i0_valid=0 is ignored; count never underflows.
- Flush, highest priority: rd_ptr, wr_ptr and count go to 0 on the next edge. A push or take in the flush cycle is discarded.
- ib_i0_valid = (count != 0), except as extended by bypass (see Configuration).
- Head fields come from entry[rd_ptr]. They are don't-care when ib_i0_valid=0, but must not be X after reset: the storage is reset to 0.
- Fault bits pass through unmodified. The queue never drops, reorders or alters a packet.

## Timing

- Reset values:
  - ifu_ib_ready=1
  - ib_i0_valid=0
  - ib_count=0
  - all ib_i0_* data outputs 0
  - pointers 0
- Without bypass, latency is 1 cycle: a packet pushed at edge N is visible at the head after edge N.
- Throughput is one push and one pop per cycle.
- Full: ifu_ib_ready=0 from the cycle count reaches DEPTH. It returns to 1 in the cycle after a pop.
- Flush: the cycle after the flush edge shows ib_i0_valid=0, ib_count=0 and ifu_ib_ready=1.
- Reset asserted mid-operation clears all state immediately (asynchronously). Outputs take their reset values while rst=1.

## Configuration

- IB_BYPASS_EN defined:
  - When count==0, ifu_i0_valid=1 and exu_flush_final=0, ib_i0_valid=1 and the ib_i0_* outputs carry the input packet combinationally (zero latency).
  - If dec_ib_take=1 in that cycle, the packet is consumed and not written; count stays 0.
  - Otherwise it is written normally.
- IB_BYPASS_EN undefined:
  - No combinational path from ifu_i0_* to ib_i0_*.
  - Minimum latency is 1 cycle.

## Test plan

- Reset, then push PCs 0x100, 0x102, 0x106, 0x10A with no take -> count reaches 4, ifu_ib_ready=0. A fifth push is refused, and the head stays PC 0x100.
- Fill to 4, then take on four consecutive cycles -> heads appear in order 0x100, 0x102, 0x106, 0x10A; count 4→0; ready=1 after the first take.
- Push and take together every cycle for 10 cycles at count=2 -> count stays 2, order is preserved, and the pointers wrap past DEPTH-1 cleanly.
- Queue at count=3, assert exu_flush_final together with push and take -> next cycle count=0, ib_i0_valid=0, and the pushed packet is never delivered.
- Push instr 0x00000013 with icaf=1, icaf_type=2, dbecc=1, then take -> the head shows identical values.
- Empty queue, push PC 0x200 with take=1 in the same cycle:
  - With IB_BYPASS_EN: ib_i0_valid=1 in that cycle with PC 0x200, and count stays 0.
  - Without IB_BYPASS_EN: ib_i0_valid=0 in that cycle, and PC 0x200 appears the next cycle with count=1.
